// File: rtl/hv_tree_pkg.sv
// Shared constants, FSM state type and accumulator width helper for the
// hypervector adder-tree accumulator.
package hv_tree_pkg;

    localparam int LANES    = 16;
    localparam int TREE_LAT = 4;

    typedef enum logic [1:0] {
        FEED  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Tree output is in_w+4 bits; summing `chunks` of them adds clog2(chunks).
    function automatic int acc_width(input int in_w, input int chunks);
        return in_w + 4 + $clog2(chunks);
    endfunction

endpackage

// File: rtl/hv_adder_tree16.sv
// 16-input, 4-stage pipelined adder tree; each level widens by one bit.
// valid/last sideband shifts alongside the data and is the only reset state.
module hv_adder_tree16
    import hv_tree_pkg::*;
#(
    parameter int IN_W = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        valid_i,
    input  logic                        last_i,
    input  logic [LANES-1:0][IN_W-1:0]  data_i,
    output logic                        valid_o,
    output logic                        last_o,
    output logic [IN_W+3:0]             sum_o
);

    logic [7:0][IN_W:0]   l1_q;
    logic [3:0][IN_W+1:0] l2_q;
    logic [1:0][IN_W+2:0] l3_q;
    logic [IN_W+3:0]      l4_q;
    logic [TREE_LAT-1:0]  vld_q;
    logic [TREE_LAT-1:0]  lst_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            l1_q[i] <= {1'b0, data_i[2*i]} + {1'b0, data_i[2*i+1]};
        end
        for (int i = 0; i < 4; i++) begin
            l2_q[i] <= {1'b0, l1_q[2*i]} + {1'b0, l1_q[2*i+1]};
        end
        for (int i = 0; i < 2; i++) begin
            l3_q[i] <= {1'b0, l2_q[2*i]} + {1'b0, l2_q[2*i+1]};
        end
        l4_q <= {1'b0, l3_q[0]} + {1'b0, l3_q[1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            lst_q <= '0;
        end else begin
            vld_q <= {vld_q[TREE_LAT-2:0], valid_i};
            lst_q <= {lst_q[TREE_LAT-2:0], last_i & valid_i};
        end
    end

    assign valid_o = vld_q[TREE_LAT-1];
    assign last_o  = lst_q[TREE_LAT-1];
    assign sum_o   = l4_q;

endmodule

// File: rtl/hv_tree_accum_ctrl.sv
// Sequences NUM_CHUNKS beats through the adder tree and accumulates one total.
// Optional HV_TREE_THRESH_EN adds thresh input and registered out_bit compare.
// States: FEED accept beats, count chunks | DRAIN wait for last partial | DONE hold total
module hv_tree_accum_ctrl
    import hv_tree_pkg::*;
#(
    parameter int IN_W       = 8,
    parameter int NUM_CHUNKS = 64
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           in_valid,
    output logic                                           in_ready,
    input  logic [LANES-1:0][IN_W-1:0]                     in_data,
    output logic                                           out_valid,
    input  logic                                           out_ready,
    output logic [acc_width(IN_W, NUM_CHUNKS)-1:0]         out_sum
`ifdef HV_TREE_THRESH_EN
    ,
    input  logic [acc_width(IN_W, NUM_CHUNKS)-1:0]         thresh,
    output logic                                           out_bit
`endif
);

    localparam int ACC_W = acc_width(IN_W, NUM_CHUNKS);
    localparam int CNT_W = $clog2(NUM_CHUNKS);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [ACC_W-1:0]    acc_sum;
    logic                accept;
    logic                last_beat;
    logic                tree_vld;
    logic                tree_lst;
    logic [IN_W+3:0]     tree_sum;

    // Gated by rst_n so the source sees no ready while reset is held.
    assign in_ready  = rst_n && (state_q == FEED);
    assign accept    = in_valid && in_ready;
    assign last_beat = (cnt_q == CNT_W'(NUM_CHUNKS - 1));
    assign acc_sum   = acc_q + ACC_W'(tree_sum);

    hv_adder_tree16 #(
        .IN_W (IN_W)
    ) u_tree (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (accept),
        .last_i  (last_beat),
        .data_i  (in_data),
        .valid_o (tree_vld),
        .last_o  (tree_lst),
        .sum_o   (tree_sum)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        if (tree_vld) begin
            acc_d = acc_sum;
        end
        case (state_q)
            FEED: begin
                if (accept) begin
                    if (last_beat) begin
                        cnt_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (tree_vld && tree_lst) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = FEED;
                end
            end
            default: state_d = FEED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FEED;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
        end
    end

    assign out_valid = (state_q == DONE);
    assign out_sum   = acc_q;

`ifdef HV_TREE_THRESH_EN
    logic out_bit_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_bit_q <= 1'b0;
        end else if (state_q == DRAIN && state_d == DONE) begin
            out_bit_q <= (acc_sum >= thresh);
        end
    end

    assign out_bit = out_bit_q;
`endif

endmodule

// File: tb/tb_hv_tree_accum_ctrl.sv
// Scenario bench for hv_tree_accum_ctrl at IN_W=8, NUM_CHUNKS=4 (ACC_W=14).
// The threshold scenario runs only when HV_TREE_THRESH_EN is defined.
module tb_hv_tree_accum_ctrl;

    localparam int IN_W       = 8;
    localparam int NUM_CHUNKS = 4;
    localparam int ACC_W      = 14;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [15:0][IN_W-1:0]  in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [ACC_W-1:0]       out_sum;
`ifdef HV_TREE_THRESH_EN
    logic [ACC_W-1:0]       thresh;
    logic                   out_bit;
`endif

    int total = 0;
    int bad   = 0;
    logic [ACC_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    hv_tree_accum_ctrl #(
        .IN_W       (IN_W),
        .NUM_CHUNKS (NUM_CHUNKS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum)
`ifdef HV_TREE_THRESH_EN
        ,
        .thresh    (thresh),
        .out_bit   (out_bit)
`endif
    );

    // Drives one vector of NUM_CHUNKS identical beats with `gap` idle cycles
    // between beats, pushes the model total, and returns at #1 after the last accept edge.
    task automatic send_vec(input logic [15:0][IN_W-1:0] beat, input int gap);
        int s;
        s = 0;
        for (int i = 0; i < 16; i++) s += int'(beat[i]);
        exp_q.push_back(ACC_W'(s * NUM_CHUNKS));
        for (int b = 0; b < NUM_CHUNKS; b++) begin
            in_data  = beat;
            in_valid = 1'b1;
            #3;
            total++;
            if (in_ready !== 1'b1) begin
                bad++;
                $display("FAIL beat_ready beat=%0d got=%b want=1", b, in_ready);
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (b < NUM_CHUNKS - 1) begin
                for (int g = 0; g < gap; g++) begin
                    #3;
                    total++;
                    if (in_ready !== 1'b1) begin
                        bad++;
                        $display("FAIL gap_ready beat=%0d got=%b want=1", b, in_ready);
                    end
                    @(posedge clk);
                    #1;
                end
            end
        end
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL ready_after_last got=%b want=0", in_ready);
        end
    endtask

    // Counts edges until out_valid is seen (bounded); caller checks the count.
    task automatic wait_out(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    function automatic logic [15:0][IN_W-1:0] fill(input logic [IN_W-1:0] v);
        logic [15:0][IN_W-1:0] r;
        for (int i = 0; i < 16; i++) r[i] = v;
        return r;
    endfunction

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
`ifdef HV_TREE_THRESH_EN
        thresh    = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        total++;
        if (out_sum !== '0) begin bad++; $display("FAIL rst_out_sum got=%0d want=0", out_sum); end
`ifdef HV_TREE_THRESH_EN
        total++;
        if (out_bit !== 1'b0) begin bad++; $display("FAIL rst_out_bit got=%b want=0", out_bit); end
`endif
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [ACC_W-1:0] e;
        send_vec(fill(8'd1), 0);
        wait_out(lat);
        e = exp_q.pop_front();
        total++;
        if (lat !== 4) begin bad++; $display("FAIL b2b_latency got=%0d want=4", lat); end
        total++;
        if (out_sum !== e) begin bad++; $display("FAIL b2b_sum got=%0d want=%0d", out_sum, e); end
        handshake();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_valid_drop got=%b want=0", out_valid); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_back got=%b want=1", in_ready); end
    endtask

    task automatic test_max_lanes();
        int lat;
        logic [ACC_W-1:0] e;
        send_vec(fill(8'd255), 0);
        wait_out(lat);
        e = exp_q.pop_front();
        total++;
        if (lat !== 4) begin bad++; $display("FAIL max_latency got=%0d want=4", lat); end
        total++;
        if (out_sum !== e || e !== 14'd16320) begin
            bad++; $display("FAIL max_sum got=%0d want=16320", out_sum);
        end
        handshake();
    endtask

    function automatic logic [15:0][IN_W-1:0] ramp();
        logic [15:0][IN_W-1:0] r;
        for (int i = 0; i < 16; i++) r[i] = IN_W'(i);
        return r;
    endfunction

    task automatic test_gaps();
        int lat;
        logic [ACC_W-1:0] e;
        send_vec(ramp(), 1);
        wait_out(lat);
        e = exp_q.pop_front();
        total++;
        if (lat !== 4) begin bad++; $display("FAIL gap_latency got=%0d want=4", lat); end
        total++;
        if (out_sum !== e) begin bad++; $display("FAIL gap_sum got=%0d want=%0d", out_sum, e); end
        handshake();
    endtask

    task automatic test_hold();
        int lat;
        logic [ACC_W-1:0] e;
        send_vec(fill(8'd7), 0);
        wait_out(lat);
        e = exp_q.pop_front();
        total++;
        if (out_sum !== e) begin bad++; $display("FAIL hold_first_sum got=%0d want=%0d", out_sum, e); end
        for (int c = 0; c < 10; c++) begin
            in_valid = c[0];
            in_data  = fill(8'd9);
            #3;
            total++;
            if (out_valid !== 1'b1) begin bad++; $display("FAIL hold_valid cyc=%0d got=%b want=1", c, out_valid); end
            total++;
            if (in_ready !== 1'b0) begin bad++; $display("FAIL hold_ready cyc=%0d got=%b want=0", c, in_ready); end
            total++;
            if (out_sum !== e) begin bad++; $display("FAIL hold_sum cyc=%0d got=%0d want=%0d", c, out_sum, e); end
            @(posedge clk);
            #1;
        end
        // Beat offered on the handshake edge must not be taken.
        in_valid = 1'b1;
        handshake();
        in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL hold_ready_back got=%b want=1", in_ready); end
        send_vec(fill(8'd2), 0);
        wait_out(lat);
        e = exp_q.pop_front();
        total++;
        if (lat !== 4) begin bad++; $display("FAIL hold_next_latency got=%0d want=4", lat); end
        total++;
        if (out_sum !== e || e !== 14'd128) begin
            bad++; $display("FAIL hold_next_sum got=%0d want=128", out_sum);
        end
        handshake();
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [ACC_W-1:0] e;
        for (int b = 0; b < 2; b++) begin
            in_data  = fill(8'd50);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready got=%b want=0", in_ready); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b want=0", out_valid); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready_back got=%b want=1", in_ready); end
        total++;
        if (out_sum !== '0) begin bad++; $display("FAIL mid_rst_sum got=%0d want=0", out_sum); end
        send_vec(fill(8'd3), 0);
        wait_out(lat);
        e = exp_q.pop_front();
        total++;
        if (lat !== 4) begin bad++; $display("FAIL mid_rst_latency got=%0d want=4", lat); end
        total++;
        if (out_sum !== e || e !== 14'd192) begin
            bad++; $display("FAIL mid_rst_sum_after got=%0d want=192", out_sum);
        end
        handshake();
    endtask

`ifdef HV_TREE_THRESH_EN
    task automatic test_thresh();
        int lat;
        logic [ACC_W-1:0] e;
        logic             eb;
        for (int k = 0; k < 2; k++) begin
            thresh = (k == 0) ? 14'd480 : 14'd481;
            eb     = (k == 0);
            send_vec(ramp(), 1);
            wait_out(lat);
            e = exp_q.pop_front();
            total++;
            if (out_sum !== e) begin bad++; $display("FAIL thr_sum k=%0d got=%0d want=%0d", k, out_sum, e); end
            // Changing thresh during DONE must not disturb the held bit.
            thresh = ~thresh;
            @(posedge clk);
            #1;
            total++;
            if (out_bit !== eb) begin bad++; $display("FAIL thr_bit k=%0d got=%b want=%b", k, out_bit, eb); end
            handshake();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_max_lanes();
        test_gaps();
        test_hold();
        test_reset_mid();
`ifdef HV_TREE_THRESH_EN
        test_thresh();
`endif
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL scoreboard_left got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
